// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared size and FSM encodings for the SRAM bus initiator
package sram_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RSP_RD  = 2'd1;
  localparam state_t ST_RSP_WR  = 2'd2;
  localparam state_t ST_RSP_ERR = 2'd3;

endpackage

// File: rtl/sram_wmask_gen.sv
// rtl/sram_wmask_gen.sv - byte-lane mask, replicated write data and alignment check
module sram_wmask_gen
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  mask,
  output logic [31:0] din,
  output logic        misaligned
);

  always_comb begin
    mask       = 4'b0000;
    din        = 32'h0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        mask = 4'b0001 << offset;
        din  = {4{wdata[7:0]}};
      end
      SZ_H: begin
        mask       = 4'b0011 << offset;
        din        = {2{wdata[15:0]}};
        misaligned = offset[0];
      end
      SZ_W: begin
        mask       = 4'b1111;
        din        = wdata;
        misaligned = |offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-outstanding read/write initiator for the on-chip SRAM
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DP = 512,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [1:0]    cmd_size,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  input  logic [DW-1:0] ram_dout
);

  localparam int RAM_WORD_AW = $clog2(DP);

  state_t                 state;
  state_t                 state_nxt;
  logic [RAM_WORD_AW-1:0] held_addr;
  logic [AW-3:0]          widx;
  logic [3:0]             mask;
  logic [31:0]            din;
  logic                   misaligned;
  logic                   out_of_range;
  logic                   legal;
  logic                   acc;

  sram_wmask_gen u_wmask_gen (
    .size       (cmd_size),
    .offset     (cmd_addr[1:0]),
    .wdata      (cmd_wdata),
    .mask       (mask),
    .din        (din),
    .misaligned (misaligned)
  );

  assign widx         = cmd_addr[AW-1:2];
  assign out_of_range = widx >= (AW-2)'(DP);
  assign legal        = ~out_of_range & (cmd_size != SZ_R) & ~misaligned;

  // Ready looks only at the response side so cmd_* never feeds back into it.
  assign rsp_valid = state != ST_IDLE;
  assign cmd_ready = rst_n & (~rsp_valid | rsp_ready);
  assign acc       = cmd_valid & cmd_ready;

  assign ram_we   = acc & ~cmd_read & legal;
  assign ram_wem  = ram_we ? MW'(mask) : '0;
  assign ram_din  = DW'(din);
  // Reads re-present the last read index so the SRAM keeps ram_dout stable.
  assign ram_addr = (acc & legal) ? AW'(widx[RAM_WORD_AW-1:0]) : AW'(held_addr);

  assign rsp_err   = state == ST_RSP_ERR;
  assign rsp_rdata = (state == ST_RSP_RD) ? ram_dout : '0;

  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (!legal)        state_nxt = ST_RSP_ERR;
      else if (cmd_read) state_nxt = ST_RSP_RD;
      else               state_nxt = ST_RSP_WR;
    end else if (rsp_valid && rsp_ready) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      held_addr <= '0;
    end else begin
      state <= state_nxt;
      if (acc && legal && cmd_read) held_addr <= widx[RAM_WORD_AW-1:0];
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed self-checking bench for sram_ctrl with a behavioural SRAM
module tb_sram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:511];

  int n_cmp;
  int n_bad;

  logic        s_ready;
  logic        s_we;
  logic [3:0]  s_wem;
  logic [31:0] s_addr;
  logic [31:0] s_din;

  sram_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_read  (cmd_read),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_wem   (ram_wem),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: latches its address whenever not writing; output register holds during writes.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
    end else begin
      ram_dout <= mem[ram_addr[8:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Presents one command, snapshots the SRAM drive just before the edge, then drops valid.
  task automatic send(input logic rd, input logic [31:0] addr, input logic [1:0] sz,
                      input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_size  = sz;
    cmd_wdata = wd;
    #1;
    s_ready = cmd_ready;
    s_we    = ram_we;
    s_wem   = ram_wem;
    s_addr  = ram_addr;
    s_din   = ram_din;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    ram_dout  = 32'h0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 2'b00;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b1;

    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_wem", 32'(ram_wem), 32'd0);
    check("rst_ram_addr", ram_addr, 32'h0);
    repeat (2) idle_cycle();
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Word write then read-back.
    send(1'b0, 32'h10, 2'b10, 32'hDEADBEEF);
    check("w1_ready", 32'(s_ready), 32'd1);
    check("w1_we", 32'(s_we), 32'd1);
    check("w1_wem", 32'(s_wem), 32'hF);
    check("w1_addr", s_addr, 32'd4);
    check("w1_din", s_din, 32'hDEADBEEF);
    check("w1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("w1_rsp_err", 32'(rsp_err), 32'd0);
    check("w1_rsp_rdata", rsp_rdata, 32'h0);
    send(1'b1, 32'h10, 2'b10, 32'h0);
    check("r1_ready", 32'(s_ready), 32'd1);
    check("r1_we", 32'(s_we), 32'd0);
    check("r1_addr", s_addr, 32'd4);
    check("r1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("r1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    check("r1_rsp_err", 32'(rsp_err), 32'd0);
    idle_cycle();
    check("r1_idle", 32'(rsp_valid), 32'd0);

    // Byte write into the top lane of an existing word.
    send(1'b0, 32'h10, 2'b10, 32'h11223344);
    send(1'b0, 32'h13, 2'b00, 32'h000000AA);
    check("wb_wem", 32'(s_wem), 32'h8);
    check("wb_din", s_din, 32'hAAAAAAAA);
    check("wb_addr", s_addr, 32'd4);
    send(1'b1, 32'h10, 2'b10, 32'h0);
    check("rb_rdata", rsp_rdata, 32'hAA223344);
    idle_cycle();

    // Stalled read response with a write waiting behind it.
    send(1'b0, 32'h20, 2'b10, 32'hCAFEF00D);
    idle_cycle();
    rsp_ready = 1'b0;
    send(1'b1, 32'h20, 2'b10, 32'h0);
    check("st_rsp_rdata0", rsp_rdata, 32'hCAFEF00D);
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_addr  = 32'h20;
    cmd_size  = 2'b00;
    cmd_wdata = 32'h00000055;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_cmd_ready", 32'(cmd_ready), 32'd0);
      check("st_ram_we", 32'(ram_we), 32'd0);
      check("st_ram_addr", ram_addr, 32'd8);
      check("st_rsp_valid", 32'(rsp_valid), 32'd1);
      check("st_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      idle_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    check("st_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("st_rel_we", 32'(ram_we), 32'd1);
    check("st_rel_wem", 32'(ram_wem), 32'h1);
    check("st_rel_rdata", rsp_rdata, 32'hCAFEF00D);
    idle_cycle();
    cmd_valid = 1'b0;
    check("st_wr_rsp_rdata", rsp_rdata, 32'h0);
    send(1'b1, 32'h20, 2'b10, 32'h0);
    check("st_readback", rsp_rdata, 32'hCAFEF055);

    // Illegal commands: misaligned half, out-of-range word, reserved size.
    send(1'b0, 32'h01, 2'b01, 32'h1234);
    check("e1_we", 32'(s_we), 32'd0);
    check("e1_err", 32'(rsp_err), 32'd1);
    check("e1_rdata", rsp_rdata, 32'h0);
    send(1'b1, 32'h802, 2'b10, 32'h0);
    check("e2_we", 32'(s_we), 32'd0);
    check("e2_addr_held", s_addr, 32'd8);
    check("e2_err", 32'(rsp_err), 32'd1);
    check("e2_rdata", rsp_rdata, 32'h0);
    send(1'b0, 32'h00, 2'b11, 32'hFFFFFFFF);
    check("e3_we", 32'(s_we), 32'd0);
    check("e3_wem", 32'(s_wem), 32'd0);
    check("e3_err", 32'(rsp_err), 32'd1);
    check("e3_rdata", rsp_rdata, 32'h0);
    send(1'b1, 32'h7FC, 2'b10, 32'h0);
    check("last_word_addr", s_addr, 32'd511);
    check("last_word_err", 32'(rsp_err), 32'd0);
    check("last_word_rdata", rsp_rdata, 32'h0);

    // Streaming writes then eight back-to-back reads.
    for (int i = 0; i < 8; i++)
      send(1'b0, 32'h40 + 32'(4 * i), 2'b10, 32'h10000000 + 32'(i) * 32'h01010101);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 32'h40 + 32'(4 * i), 2'b10, 32'h0);
      check("stream_ready", 32'(s_ready), 32'd1);
      check("stream_valid", 32'(rsp_valid), 32'd1);
      check("stream_rdata", rsp_rdata, 32'h10000000 + 32'(i) * 32'h01010101);
    end
    idle_cycle();

    // Reset while a read response is pending, with a write presented.
    rsp_ready = 1'b0;
    send(1'b1, 32'h20, 2'b10, 32'h0);
    check("rr_valid_pre", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_read  = 1'b0;
    cmd_addr  = 32'h10;
    cmd_size  = 2'b10;
    cmd_wdata = 32'h0BADBEEF;
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_valid_drop", 32'(rsp_valid), 32'd0);
    check("rr_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rr_we", 32'(ram_we), 32'd0);
    idle_cycle();
    check("rr_we_edge", 32'(ram_we), 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("rr_post_ready", 32'(cmd_ready), 32'd1);
    check("rr_post_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    idle_cycle();
    send(1'b1, 32'h10, 2'b10, 32'h0);
    check("rr_no_write", rsp_rdata, 32'hAA223344);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
